// File: rtl/timer_countdown_pkg.sv
// Shared constants for the cooking-time countdown: FSM encodings, BCD digit limits
// and the keypad digit bound.
package timer_countdown_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SET   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] KEY_MAX      = 4'd9;

  // A seconds digit shifted into the tens position cannot exceed 5.
  function automatic logic [3:0] clamp_tens(input logic [3:0] digit);
    return (digit > SEC_TENS_MAX) ? SEC_TENS_MAX : digit;
  endfunction

endpackage

// File: rtl/timer_countdown_bcd_digit_down.sv
// One BCD down-counting digit with parallel load, borrow chain and zero flag.
// Wraps 0 -> MAX when decremented with borrow-in asserted.
module timer_countdown_bcd_digit_down #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  input  logic       i_borrow_in,
  output logic [3:0] o_digit,
  output logic       o_zero,
  output logic       o_borrow_out
);

  logic [3:0] r_digit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_digit <= 4'd0;
    end else if (i_clear) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_dec && i_borrow_in) begin
      r_digit <= (r_digit == 4'd0) ? MAX : r_digit - 1'b1;
    end
  end

  assign o_digit      = r_digit;
  assign o_zero       = (r_digit == 4'd0);
  assign o_borrow_out = i_borrow_in && o_zero;

endmodule

// File: rtl/timer_countdown.sv
// Cooking-time countdown: keypad BCD entry of M:SS, one-second countdown while the
// magnetron runs, timer_done level / done_pulse and the 3-digit display.
module timer_countdown
  import timer_countdown_pkg::*;
#(
  parameter int CLK_DIV = 100,
  parameter int DIV_W   = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  input  logic       mag_on,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse
);

  // state    | meaning
  // ST_IDLE  | time 0:00, never started
  // ST_SET   | time entered, stopped
  // ST_RUN   | counting down while mag_on
  // ST_PAUSE | mag_on dropped mid-run, time frozen
  // ST_DONE  | reached 0:00 by counting

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [DIV_W-1:0] r_presc;
  logic             r_timer_done;
  logic             r_done_pulse;

  logic w_clear, w_counting, w_tick, w_dec, w_key_acc;
  logic w_ones_zero, w_tens_zero, w_min_zero;
  logic w_ones_borrow, w_tens_borrow, w_all_zero;
  logic w_key_zero, w_last_sec;

  assign w_clear    = !clearn;
  assign w_counting = (r_state == ST_RUN) && mag_on;
  assign w_tick     = w_counting && (r_presc == DIV_W'(CLK_DIV - 1));
  assign w_dec      = w_tick && !w_all_zero;
  assign w_key_acc  = key_valid && (key_data <= KEY_MAX) && !mag_on && (r_state != ST_RUN);

  // After a shift the old tens becomes minutes and the old ones becomes tens.
  assign w_key_zero = w_tens_zero && w_ones_zero && (key_data == 4'd0);
  assign w_last_sec = w_min_zero && w_tens_zero && (sec_ones == 4'd1);

  timer_countdown_bcd_digit_down #(.MAX(DIGIT_MAX)) u_sec_ones (
    .clk          (clk),
    .resetn       (resetn),
    .i_clear      (w_clear),
    .i_load       (w_key_acc),
    .i_load_val   (key_data),
    .i_dec        (w_dec),
    .i_borrow_in  (1'b1),
    .o_digit      (sec_ones),
    .o_zero       (w_ones_zero),
    .o_borrow_out (w_ones_borrow)
  );

  timer_countdown_bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk          (clk),
    .resetn       (resetn),
    .i_clear      (w_clear),
    .i_load       (w_key_acc),
    .i_load_val   (clamp_tens(sec_ones)),
    .i_dec        (w_dec),
    .i_borrow_in  (w_ones_borrow),
    .o_digit      (sec_tens),
    .o_zero       (w_tens_zero),
    .o_borrow_out (w_tens_borrow)
  );

  // Borrow out of the minutes digit is only set when all three digits are zero.
  timer_countdown_bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_ones (
    .clk          (clk),
    .resetn       (resetn),
    .i_clear      (w_clear),
    .i_load       (w_key_acc),
    .i_load_val   (sec_tens),
    .i_dec        (w_dec),
    .i_borrow_in  (w_tens_borrow),
    .o_digit      (min_ones),
    .o_zero       (w_min_zero),
    .o_borrow_out (w_all_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc <= '0;
    end else if (w_clear || w_key_acc || w_tick) begin
      r_presc <= '0;
    end else if (w_counting) begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) begin
      w_state_nxt = ST_IDLE;
    end else if (w_key_acc) begin
      w_state_nxt = w_key_zero ? ST_IDLE : ST_SET;
    end else begin
      case (r_state)
        ST_SET, ST_PAUSE: begin
          if (mag_on) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!mag_on)                 w_state_nxt = ST_PAUSE;
          else if (w_dec && w_last_sec) w_state_nxt = ST_DONE;
        end
        ST_IDLE, ST_DONE: ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Done flags are computed from the next digit values so they move with the digits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timer_done <= 1'b1;
      r_done_pulse <= 1'b0;
    end else begin
      r_done_pulse <= !w_clear && w_dec && w_last_sec;
      if (w_clear) begin
        r_timer_done <= 1'b1;
      end else if (w_key_acc) begin
        r_timer_done <= w_key_zero;
      end else if (w_dec) begin
        r_timer_done <= w_last_sec;
      end
    end
  end

  assign timer_done = r_timer_done;
  assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_timer_countdown.sv
// Bench for timer_countdown: directed scenarios then random keypad/magnetron/clear
// traffic, all checked every cycle against a seconds-based reference model.
module tb_timer_countdown;

  localparam int CLK_DIV = 4;
  localparam int DIV_W   = 7;

  logic       clk       = 1'b0;
  logic       resetn    = 1'b0;
  logic       clearn    = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_data  = 4'd0;
  logic       mag_on    = 1'b0;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic       timer_done, done_pulse;

  int checks   = 0;
  int failures = 0;

  // Reference state: remaining time in plain seconds, position within the current
  // second, whether the countdown is running, and the expected done pulse.
  int m_secs      = 0;
  int m_phase     = 0;
  bit m_run       = 1'b0;
  bit m_pulse     = 1'b0;
  int pulse_count = 0;

  timer_countdown #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clearn     (clearn),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .mag_on     (mag_on),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] disp_of(input int secs);
    return {4'(secs / 60), 4'((secs % 60) / 10), 4'(secs % 10)};
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "/disp"},  {min_ones, sec_tens, sec_ones}, disp_of(m_secs));
    check({tag, "/done"},  {11'd0, timer_done}, {11'd0, (m_secs == 0)});
    check({tag, "/pulse"}, {11'd0, done_pulse}, {11'd0, m_pulse});
  endtask

  task automatic model_reset();
    m_secs  = 0;
    m_phase = 0;
    m_run   = 1'b0;
    m_pulse = 1'b0;
  endtask

  // Advance the model over one clock with the current inputs, then compare.
  task automatic step(input string tag);
    int d1, d0, nsecs, nphase;
    bit key_ok, tick, nrun, npulse;
    d1     = (m_secs % 60) / 10;
    d0     = m_secs % 10;
    key_ok = key_valid && (key_data <= 4'd9) && !mag_on && !m_run;
    tick   = m_run && mag_on && (m_phase == CLK_DIV - 1);
    nsecs  = m_secs;
    nphase = m_phase;
    npulse = 1'b0;
    nrun   = 1'b0;
    if (clearn) begin
      if (key_ok) begin
        nsecs  = d1 * 60 + (d0 > 5 ? 5 : d0) * 10 + int'(key_data);
        nphase = 0;
      end else if (m_run && mag_on) begin
        nphase = (m_phase + 1) % CLK_DIV;
        if (tick && m_secs > 0) begin
          nsecs  = m_secs - 1;
          npulse = (nsecs == 0);
        end
      end
      nrun = mag_on && (m_secs != 0) && !(tick && m_secs == 1);
    end else begin
      nsecs  = 0;
      nphase = 0;
    end
    @(posedge clk);
    m_secs  = nsecs;
    m_phase = nphase;
    m_run   = nrun;
    m_pulse = npulse;
    if (m_pulse) pulse_count++;
    #1;
    check_outputs(tag);
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_data  = k;
    step("key");
    key_valid = 1'b0;
    step("key_gap");
  endtask

  task automatic clear_pulse();
    clearn = 1'b0;
    step("clear");
    clearn = 1'b1;
  endtask

  initial begin
    bit seen;

    #12;
    check_outputs("reset");
    resetn = 1'b1;
    step("idle");

    // 1:30 counted down past 1:00 -> 0:59 and on to 0:58
    press(4'd1); press(4'd3); press(4'd0);
    check("entry_130", {min_ones, sec_tens, sec_ones}, 12'h130);
    mag_on = 1'b1;
    repeat (CLK_DIV * 32 + 2) step("run_130");
    check("after_32s", {min_ones, sec_tens, sec_ones}, 12'h058);
    mag_on = 1'b0;
    step("stop");
    clear_pulse();
    check("cleared", {min_ones, sec_tens, sec_ones}, 12'h000);

    // 0:02 to done, single pulse, nothing moves with mag_on held
    press(4'd0); press(4'd0); press(4'd2);
    check("entry_002", {min_ones, sec_tens, sec_ones}, 12'h002);
    pulse_count = 0;
    mag_on = 1'b1;
    repeat (20) step("run_002");
    check("done_disp", {min_ones, sec_tens, sec_ones}, 12'h000);
    check("done_level", {11'd0, timer_done}, 12'd1);
    check("pulse_count", 12'(pulse_count), 12'd1);
    mag_on = 1'b0;
    step("done_idle");

    // tens clamp on shift and out-of-range key rejection
    press(4'd7); press(4'd0);
    check("clamp_050", {min_ones, sec_tens, sec_ones}, 12'h050);
    press(4'd12);
    check("key12_ignored", {min_ones, sec_tens, sec_ones}, 12'h050);
    check("nonzero_done_low", {11'd0, timer_done}, 12'd0);

    // pause mid-second, key ignored while running, resume
    clear_pulse();
    press(4'd1); press(4'd0);
    mag_on = 1'b1;
    repeat (3) step("to_phase2");
    mag_on = 1'b0;
    repeat (10) step("paused");
    check("pause_frozen", {min_ones, sec_tens, sec_ones}, 12'h010);
    mag_on    = 1'b1;
    key_valid = 1'b1;
    key_data  = 4'd5;
    step("key_mag_on");
    key_valid = 1'b0;
    repeat (12) step("resume");
    mag_on = 1'b0;
    step("stop2");

    // clear, key and tick all in one cycle
    clear_pulse();
    press(4'd3); press(4'd0);
    mag_on = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (m_run && m_phase == CLK_DIV - 1) begin
        seen = 1'b1;
        break;
      end
      step("align_tick");
    end
    check("tick_align", {11'd0, seen}, 12'd1);
    clearn    = 1'b0;
    key_valid = 1'b1;
    key_data  = 4'd4;
    step("clr_key_tick");
    clearn    = 1'b1;
    key_valid = 1'b0;
    check("clear_wins", {min_ones, sec_tens, sec_ones}, 12'h000);
    repeat (6) step("idle_mag_on");
    mag_on = 1'b0;
    step("mag_off");
    press(4'd1);
    mag_on = 1'b1;
    repeat (8) step("presc_from_zero");
    mag_on = 1'b0;
    step("mag_off2");

    // asynchronous reset in the middle of a run
    press(4'd5); press(4'd0); press(4'd0);
    check("entry_500", {min_ones, sec_tens, sec_ones}, 12'h500);
    mag_on = 1'b1;
    repeat (9) step("run_500");
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    check("async_reset_disp", {min_ones, sec_tens, sec_ones}, 12'h000);
    #1 resetn = 1'b1;
    mag_on = 1'b0;

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) mag_on = ~mag_on;
      key_valid = ($urandom_range(3) == 0);
      key_data  = 4'($urandom_range(15));
      clearn    = ($urandom_range(63) != 0);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
